// File: rtl/tlc_pkg.sv
// Shared phase encodings, lamp patterns and default timing for the traffic
// phase sequencer.
package tlc_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED1  = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        RED2  = 3'd5,
        EMERG = 3'd6
    } phase_t;

    // Lamp bundles are {R,Y,G}.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam int DEF_CLK_HZ   = 50000000;
    localparam int DEF_GREEN_S  = 12;
    localparam int DEF_YELLOW_S = 3;
    localparam int DEF_ALLRED_S = 1;
    localparam int DEF_PED_CUT  = 3;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_HZ clocks; clr holds the
// count at zero so the next tick lands a full period after clr drops.
module tick_gen #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic light phase sequencer with emergency override and an
// optional pedestrian green-truncation feature enabled by TLC_PED_REQ_EN.
module traffic_phase_sequencer
    import tlc_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int GREEN_S  = DEF_GREEN_S,
    parameter int YELLOW_S = DEF_YELLOW_S,
    parameter int ALLRED_S = DEF_ALLRED_S,
    parameter int PED_CUT  = DEF_PED_CUT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       emerg_i,
    input  logic       ped_req_i,
    output logic       ped_ack_o,
    output logic [2:0] ns_light_o,
    output logic [2:0] ew_light_o,
    output logic [3:0] count_o,
    output logic [2:0] state_o
);

    localparam logic [3:0] GREEN  = 4'(GREEN_S);
    localparam logic [3:0] YELLOW = 4'(YELLOW_S);
    localparam logic [3:0] ALLRED = 4'(ALLRED_S);
    localparam logic [3:0] PED    = 4'(PED_CUT);

    phase_t     state, state_nxt;
    logic [3:0] count, count_nxt;
    logic       tick, clr, ack_nxt;

    function automatic phase_t succ(input phase_t p);
        case (p)
            NS_G:    return NS_Y;
            NS_Y:    return RED1;
            RED1:    return EW_G;
            EW_G:    return EW_Y;
            EW_Y:    return RED2;
            default: return NS_G;
        endcase
    endfunction

    function automatic logic [3:0] dur(input phase_t p);
        case (p)
            NS_G, EW_G: return GREEN;
            NS_Y, EW_Y: return YELLOW;
            default:    return ALLRED;
        endcase
    endfunction

    // Prescaler sits at zero through emergency so RED2 after release is full length.
    assign clr = (state == EMERG);

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .tick (tick)
    );

`ifdef TLC_PED_REQ_EN
    logic pending;
    logic ack;

    // A request in the clearing cycle wins over the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= 1'b0;
            ack     <= 1'b0;
        end else begin
            pending <= ped_req_i | (pending & ~ack_nxt);
            ack     <= ack_nxt;
        end
    end

    assign ped_ack_o = ack;
`else
    logic unused_ped;
    assign unused_ped = ped_req_i;
    assign ped_ack_o  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ack_nxt   = 1'b0;
        if (emerg_i) begin
            state_nxt = EMERG;
            count_nxt = 4'd0;
        end else if (state == EMERG) begin
            state_nxt = RED2;
            count_nxt = ALLRED;
        end else if (tick) begin
`ifdef TLC_PED_REQ_EN
            ack_nxt = pending && (state == NS_G || state == EW_G);
`endif
            if (ack_nxt && count > PED) begin
                count_nxt = PED;
            end else if (count <= 4'd1) begin
                state_nxt = succ(state);
                count_nxt = dur(succ(state));
            end else begin
                count_nxt = count - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RED2;
            count <= ALLRED;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        ns_light_o = LAMP_R;
        ew_light_o = LAMP_R;
        case (state)
            NS_G:    ns_light_o = LAMP_G;
            NS_Y:    ns_light_o = LAMP_Y;
            EW_G:    ew_light_o = LAMP_G;
            EW_Y:    ew_light_o = LAMP_Y;
            default: ;
        endcase
    end

    assign count_o = count;
    assign state_o = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer: stimulus queues the expected
// phase/count events, a negedge monitor pops and checks each observed change.
module tb_traffic_phase_sequencer;
    import tlc_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       emerg_i = 1'b0;
    logic       ped_req_i = 1'b0;
    logic       ped_ack_o;
    logic [2:0] ns_light_o, ew_light_o, state_o;
    logic [3:0] count_o;

    traffic_phase_sequencer #(
        .CLK_HZ(4), .GREEN_S(12), .YELLOW_S(3), .ALLRED_S(1), .PED_CUT(3)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .emerg_i    (emerg_i),
        .ped_req_i  (ped_req_i),
        .ped_ack_o  (ped_ack_o),
        .ns_light_o (ns_light_o),
        .ew_light_o (ew_light_o),
        .count_o    (count_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [3:0] cnt;
        logic       ack;
        logic [2:0] ns;
        logic [2:0] ew;
        int         dly;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   base = 0;
    int   last_cyc = 0;
    bit   mon_en = 1'b0;
    logic [2:0] prev_st = 3'd5;
    logic [3:0] prev_cnt = 4'd1;

    always @(posedge clk) cyc++;

    // Monitor: every change of phase/count or any ack cycle is one event.
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (mon_en && (state_o != prev_st || count_o != prev_cnt || ped_ack_o)) begin
            checks++;
            d = cyc - last_cyc;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got state=%0d count=%0d ack=%0b after %0d cycles, required no event",
                         state_o, count_o, ped_ack_o, d);
            end else begin
                e = q.pop_front();
                if (state_o !== e.st || count_o !== e.cnt || ped_ack_o !== e.ack ||
                    ns_light_o !== e.ns || ew_light_o !== e.ew || d != e.dly) begin
                    errors++;
                    $display("FAIL event: got st=%0d cnt=%0d ack=%0b ns=%b ew=%b dly=%0d, required st=%0d cnt=%0d ack=%0b ns=%b ew=%b dly=%0d",
                             state_o, count_o, ped_ack_o, ns_light_o, ew_light_o, d,
                             e.st, e.cnt, e.ack, e.ns, e.ew, e.dly);
                end
            end
            last_cyc = cyc;
        end
        prev_st  = state_o;
        prev_cnt = count_o;
    end

    task automatic push(input logic [2:0] st, input int c, input logic a, input int d);
        exp_t e;
        e.st = st; e.cnt = 4'(c); e.ack = a; e.dly = d;
        e.ns = LAMP_R; e.ew = LAMP_R;
        case (st)
            3'd0: e.ns = 3'b001;
            3'd1: e.ns = 3'b010;
            3'd3: e.ew = 3'b001;
            3'd4: e.ew = 3'b010;
            default: ;
        endcase
        q.push_back(e);
    endtask

    // First n tick events of an undisturbed cycle, starting at NS_G entry.
    task automatic exp_normal(input int n);
        logic [2:0] seq [6];
        int         dur [6];
        int         k = 0;
        seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        dur = '{12, 3, 1, 12, 3, 1};
        while (k < n)
            for (int p = 0; p < 6 && k < n; p++)
                for (int c = dur[p]; c >= 1 && k < n; c--) begin
                    push(seq[p], c, 1'b0, 4);
                    k++;
                end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, state_o, 5);
        check({tag, "_count"}, count_o, 1);
        check({tag, "_ns"}, ns_light_o, 3'b100);
        check({tag, "_ew"}, ew_light_o, 3'b100);
        check({tag, "_ack"}, ped_ack_o, 0);
    endtask

    task automatic wait_to(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    task automatic start_test();
        @(negedge clk) rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn     = 1'b1;
        base     = cyc;
        last_cyc = cyc;
        mon_en   = 1'b1;
    endtask

    task automatic end_window(input string name, input int n);
        wait_to(n);
        mon_en = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL %s_drain: got %0d missing events, required 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        @(posedge clk) #1;
        check_reset_state("reset_held");

        // 100 ticks of undisturbed cycling, 4 clocks per tick.
        exp_normal(100);
        start_test();
        end_window("normal", 100 * 4 + 2);

        // Pedestrian pulse while NS_G shows 10.
`ifdef TLC_PED_REQ_EN
        exp_normal(3);
        push(3'd0, 3, 1'b1, 4);
        push(3'd0, 2, 1'b0, 4);
        push(3'd0, 1, 1'b0, 4);
        push(3'd1, 3, 1'b0, 4);
`else
        exp_normal(7);
`endif
        start_test();
        wait_to(12);
        ped_req_i = 1'b1;
        wait_to(13);
        ped_req_i = 1'b0;
        end_window("ped_ns", 7 * 4 + 2);

        // Pulse in RED1 acks on the first EW_G tick; a second pulse in the
        // clearing cycle keeps pending set, giving a non-truncating ack next.
`ifdef TLC_PED_REQ_EN
        exp_normal(17);
        push(3'd3, 3, 1'b1, 4);
        push(3'd3, 2, 1'b1, 4);
        push(3'd3, 1, 1'b0, 4);
        push(3'd4, 3, 1'b0, 4);
`else
        exp_normal(21);
`endif
        start_test();
        wait_to(65);
        ped_req_i = 1'b1;
        wait_to(66);
        ped_req_i = 1'b0;
        wait_to(71);
        ped_req_i = 1'b1;
        wait_to(72);
        ped_req_i = 1'b0;
        end_window("ped_ew", 21 * 4 + 2);

        // Emergency raised at EW_G count 7 for 10 cycles.
        exp_normal(22);
        push(3'd6, 0, 1'b0, 2);
        push(3'd5, 1, 1'b0, 10);
        push(3'd0, 12, 1'b0, 4);
        push(3'd0, 11, 1'b0, 4);
        start_test();
        wait_to(89);
        emerg_i = 1'b1;
        wait_to(99);
        emerg_i = 1'b0;
        end_window("emerg", 110);

        // Asynchronous reset in the middle of NS_Y.
        start_test();
        mon_en = 1'b0;
        wait_to(54);
        check("pre_reset_state", state_o, 1);
        #2 rstn = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        check_reset_state("async_reset_held");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
